// File: rtl/sram_pkg.sv
// Shared types and helpers for the pipelined 1R1W SRAM: clear-FSM state
// encoding and the per-lane write merge used by both the write port and bypass.
package sram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sramState_e;

    // Widest word / lane count the merge helper supports; instances are cast down.
    localparam int unsigned MAX_WIDTH  = 1024;
    localparam int unsigned MAX_LANES  = 64;
    localparam int unsigned BIT_IDX_W  = $clog2(MAX_WIDTH);
    localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

    // Lanes with mask set take newWord, all other bits keep oldWord.
    function automatic logic [MAX_WIDTH-1:0] laneMerge(
        input logic [MAX_WIDTH-1:0] oldWord,
        input logic [MAX_WIDTH-1:0] newWord,
        input logic [MAX_LANES-1:0] mask,
        input int unsigned          wordSize
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = oldWord;
        for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
            if (mask[LANE_IDX_W'(b / wordSize)]) begin
                merged[BIT_IDX_W'(b)] = newWord[BIT_IDX_W'(b)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Valid-tagged read delay line: DELAY-1 unreset data stages followed by a
// reset output register that only updates on a valid slot.
module sram_read_pipe #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DELAY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    output logic [WIDTH-1:0] outData
);

    logic             tailVld;
    logic [WIDTH-1:0] tailDat;

    if (DELAY == 1) begin : gNoStage
        assign tailVld = inValid;
        assign tailDat = inData;
    end else begin : gStages
        localparam int unsigned STG_W = (DELAY - 1) * WIDTH;

        logic [DELAY-2:0] stgVld;
        logic [STG_W-1:0] stgDat;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stgVld <= '0;
            end else begin
                stgVld <= (DELAY - 1)'({stgVld, inValid});
            end
        end

        // Data stages shift unconditionally; validity travels alongside.
        always_ff @(posedge clk) begin
            stgDat <= STG_W'({stgDat, inData});
        end

        assign tailVld = stgVld[DELAY-2];
        assign tailDat = stgDat[STG_W-1 -: WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else begin
            outValid <= tailVld;
            if (tailVld) begin
                outData <= tailDat;
            end
        end
    end

endmodule

// File: rtl/sram_pipe.sv
// Parametrised 1R1W SRAM with programmable read latency, optional same-cycle
// write-to-read bypass and a post-reset hardware clear sequence.
module sram_pipe
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH          = 512,
    parameter int unsigned LOG_DEPTH      = 7,
    parameter int unsigned WORDSIZE       = 64,
    parameter int unsigned DELAY          = 1,
    parameter int unsigned BYPASS         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      ready,
    input  logic                      rd_en,
    input  logic [LOG_DEPTH-1:0]      rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    input  logic [LOG_DEPTH-1:0]      wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/WORDSIZE-1:0] wr_en
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;
    localparam sramState_e  RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    if (DELAY < 1) begin : gBadDelay
        $fatal(1, "sram_pipe: DELAY must be >= 1");
    end
    if (WORDSIZE == 0 || (WIDTH % WORDSIZE) != 0) begin : gBadLanes
        $fatal(1, "sram_pipe: WIDTH must be a multiple of WORDSIZE");
    end
    if (LOG_DEPTH < 1) begin : gBadDepth
        $fatal(1, "sram_pipe: LOG_DEPTH must be >= 1");
    end
    if (WIDTH > MAX_WIDTH || (WIDTH / WORDSIZE) > MAX_LANES) begin : gTooWide
        $fatal(1, "sram_pipe: geometry exceeds lane-merge helper limits");
    end

    logic [WIDTH-1:0]     mem [DEPTH];
    sramState_e           state, stateNext;
    logic [LOG_DEPTH-1:0] clrCnt, clrCntNext;
    logic                 readyNext;
    logic                 wrActive;
    logic                 rdAccept;
    logic [WIDTH-1:0]     wrMerged;
    logic [WIDTH-1:0]     rdSample;

    // Clear FSM: walks every entry once, then parks in RUN until the next reset.
    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        case (state)
            CLEAR: begin
                clrCntNext = clrCnt + 1'b1;
                if (clrCnt == LOG_DEPTH'(DEPTH - 1)) begin
                    stateNext = RUN;
                end
            end
            RUN:     stateNext = RUN;
            default: stateNext = RESET_STATE;
        endcase
        readyNext = (stateNext == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RESET_STATE;
            clrCnt <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= stateNext;
            clrCnt <= clrCntNext;
            ready  <= readyNext;
        end
    end

    assign wrActive = ready && (|wr_en);
    assign rdAccept = ready && rd_en;
    assign wrMerged = WIDTH'(laneMerge(MAX_WIDTH'(mem[wr_addr]), MAX_WIDTH'(wr_data),
                                       MAX_LANES'(wr_en), WORDSIZE));

    // Same-address bypass shows the merged word; otherwise the pre-edge contents.
    assign rdSample = ((BYPASS != 0) && wrActive && (wr_addr == rd_addr)) ? wrMerged
                                                                          : mem[rd_addr];

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clrCnt] <= '0;
        end else if (wrActive) begin
            mem[wr_addr] <= wrMerged;
        end
    end

    sram_read_pipe #(
        .WIDTH (WIDTH),
        .DELAY (DELAY)
    ) uReadPipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .inValid  (rdAccept),
        .inData   (rdSample),
        .outValid (rd_valid),
        .outData  (rd_data)
    );

endmodule

// File: tb/tb_sram_pipe.sv
// Directed bench for sram_pipe: two builds (DELAY 3 with bypass, DELAY 4
// without) share stimulus; a reference array feeds per-build expected queues.
module tb_sram_pipe;

    localparam int W     = 128;
    localparam int LD    = 4;
    localparam int DEPTH = 16;
    localparam int DA    = 3;
    localparam int DB    = 4;

    typedef struct {
        logic [W-1:0] data;
        int           issue;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rd_en;
    logic [LD-1:0] rd_addr;
    logic [LD-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [1:0]    wr_en;

    logic          readyA, vldA, readyB, vldB;
    logic [W-1:0]  dataA, dataB;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          qA[$];
    exp_t          qB[$];
    logic [W-1:0]  model [DEPTH];
    logic [W-1:0]  lastA = '0;
    logic [W-1:0]  lastB = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_pipe #(.WIDTH(W), .LOG_DEPTH(LD), .WORDSIZE(64), .DELAY(DA), .BYPASS(1),
                .CLEAR_ON_RESET(1)) dutA (
        .clk(clk), .reset_n(reset_n), .ready(readyA), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(dataA), .rd_valid(vldA), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en));

    sram_pipe #(.WIDTH(W), .LOG_DEPTH(LD), .WORDSIZE(64), .DELAY(DB), .BYPASS(0),
                .CLEAR_ON_RESET(1)) dutB (
        .clk(clk), .reset_n(reset_n), .ready(readyB), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(dataB), .rd_valid(vldB), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                           input logic [1:0] m);
        logic [W-1:0] r;
        r = o;
        for (int l = 0; l < 2; l++) if (m[l]) r[l*64 +: 64] = n[l*64 +: 64];
        return r;
    endfunction

    // Build A scoreboard: order, data and exact latency; overdue entries are errors.
    always @(negedge clk) begin
        exp_t e;
        if (vldA === 1'b1) begin
            checks++;
            assert (qA.size() != 0) else begin
                errors++;
                $error("FAIL A_spurious_valid: observed rd_valid=1 expected 0 at cycle %0d", cyc);
            end
            if (qA.size() != 0) begin
                e = qA.pop_front();
                chk("A_data", dataA, e.data);
                chk("A_latency", W'(cyc - e.issue), W'(DA - 1));
                lastA = e.data;
            end
        end
        if (qA.size() != 0) begin
            checks++;
            assert (cyc - qA[0].issue <= DA - 1) else begin
                errors++;
                $error("FAIL A_timeout: observed no rd_valid after %0d cycles expected %0d",
                       cyc - qA[0].issue, DA - 1);
                void'(qA.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vldB === 1'b1) begin
            checks++;
            assert (qB.size() != 0) else begin
                errors++;
                $error("FAIL B_spurious_valid: observed rd_valid=1 expected 0 at cycle %0d", cyc);
            end
            if (qB.size() != 0) begin
                e = qB.pop_front();
                chk("B_data", dataB, e.data);
                chk("B_latency", W'(cyc - e.issue), W'(DB - 1));
                lastB = e.data;
            end
        end
        if (qB.size() != 0) begin
            checks++;
            assert (cyc - qB[0].issue <= DB - 1) else begin
                errors++;
                $error("FAIL B_timeout: observed no rd_valid after %0d cycles expected %0d",
                       cyc - qB[0].issue, DB - 1);
                void'(qB.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rd_en = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) step();
    endtask

    // One cycle of traffic; expectations assume the array is ready.
    task automatic drive(input logic rdEn, input int rdA, input logic [1:0] wrEn,
                         input int wrA, input logic [W-1:0] wrD);
        exp_t e;
        rd_en = rdEn; rd_addr = LD'(rdA); wr_en = wrEn; wr_addr = LD'(wrA); wr_data = wrD;
        if (rdEn) begin
            e.issue = cyc + 1;
            e.data  = (wrA == rdA) ? merge(model[rdA], wrD, wrEn) : model[rdA];
            qA.push_back(e);
            e.data  = model[rdA];
            qB.push_back(e);
        end
        if (wrEn != 2'b00) model[wrA] = merge(model[wrA], wrD, wrEn);
        step();
    endtask

    // Assert reset, check reset state, release and time the clear while hammering inputs.
    task automatic resetSeq();
        reset_n = 1'b0;
        quiet();
        qA.delete();
        qB.delete();
        #1;
        chk("A_ready_rst", W'(readyA), '0);
        chk("B_ready_rst", W'(readyB), '0);
        chk("A_valid_rst", W'(vldA), '0);
        chk("B_valid_rst", W'(vldB), '0);
        chk("A_data_rst", dataA, '0);
        chk("B_data_rst", dataB, '0);
        repeat (3) step();
        chk("A_valid_in_rst", W'(vldA), '0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset_n = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd3; wr_en = 2'b11; wr_addr = 4'd3; wr_data = {4{32'hDEADBEEF}};
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("A_ready_clear", W'(readyA), W'(k == DEPTH));
            chk("B_ready_clear", W'(readyB), W'(k == DEPTH));
        end
        quiet();
    endtask

    initial begin
        quiet();
        resetSeq();
        for (int a = 0; a < DEPTH; a++) drive(1'b1, a, 2'b00, 0, '0);
        idle(8);

        drive(1'b0, 0, 2'b11, 5, {16{8'hA5}});
        drive(1'b1, 5, 2'b00, 0, '0);
        drive(1'b1, 6, 2'b00, 0, '0);
        drive(1'b1, 5, 2'b00, 0, '0);
        idle(8);

        drive(1'b0, 0, 2'b11, 2, '1);
        drive(1'b0, 0, 2'b01, 2, '0);
        drive(1'b1, 2, 2'b00, 0, '0);
        idle(8);

        drive(1'b0, 0, 2'b11, 7, {16{8'h11}});
        drive(1'b1, 7, 2'b11, 7, {16{8'h22}});
        drive(1'b1, 7, 2'b00, 0, '0);
        drive(1'b0, 0, 2'b11, 8, {16{8'h33}});
        drive(1'b1, 8, 2'b01, 8, {16{8'h44}});
        drive(1'b1, 8, 2'b00, 0, '0);
        drive(1'b1, 9, 2'b11, 10, {16{8'h55}});
        drive(1'b1, 10, 2'b00, 0, '0);
        drive(1'b1, 5, 2'b00, 0, '0);
        drive(1'b0, 0, 2'b11, 5, {16{8'h66}});
        drive(1'b1, 5, 2'b00, 0, '0);
        idle(8);

        for (int i = 0; i < 3; i++) begin
            chk("A_hold_valid", W'(vldA), '0);
            chk("B_hold_valid", W'(vldB), '0);
            chk("A_hold_data", dataA, lastA);
            chk("B_hold_data", dataB, lastB);
            step();
        end

        drive(1'b1, 5, 2'b00, 0, '0);
        idle(1);
        resetSeq();
        drive(1'b1, 5, 2'b00, 0, '0);
        drive(1'b1, 7, 2'b00, 0, '0);
        drive(1'b1, 15, 2'b00, 0, '0);
        idle(8);

        chk("A_pending", W'(qA.size()), '0);
        chk("B_pending", W'(qB.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
